input_frontend: RTL and testbench

Synchronizes and debounces the board push-button and the 16 instruction switches, then presents a stable `{opcode, instr}` word and a single-cycle `btn_edge` strobe to `cpu_core`. It sits directly upstream of `cpu_core`. Each accepted press latches the switches once, so the core sees an instruction that stays constant for the whole bit-serial execution. Presses made while the core reports busy are rejected and flagged.

---
 rtl/input_frontend.sv | 131 +++++++++++++
 tb/tb_input_frontend.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_frontend.sv
// Button/switch front end for cpu_core: synchronizes the raw inputs, debounces the
// push-button and latches the instruction switches once per accepted press.
module input_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_raw,
  input  logic [15:0] sw,
  input  logic        busy,
  output logic [3:0]  opcode,
  output logic [11:0] instr,
  output logic        btn_edge,
  output logic        btn_level,
  output logic        btn_drop
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0]       btn_sync_q;
  logic [SYNC_STAGES-1:0][15:0] sw_sync_q;
  logic                         btn_s;
  logic [15:0]                  sw_s;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    opcode_q;
  logic [11:0]   instr_q;
  logic          edge_q;
  logic          drop_q;
  logic          level_q;

  // Synchronizer chains; only the last stage is used downstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_sync_q <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  // Debounce FSM with registered pulses, level and instruction latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opcode_q <= 4'd0;
      instr_q  <= 12'd0;
      edge_q   <= 1'b0;
      drop_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      edge_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            // busy only matters here: a press during execution is flagged, not latched
            if (busy) begin
              drop_q <= 1'b1;
            end else begin
              edge_q   <= 1'b1;
              opcode_q <= sw_s[15:12];
              instr_q  <= sw_s[11:0];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end else begin
            state_q <= PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign opcode    = opcode_q;
  assign instr     = instr_q;
  assign btn_edge  = edge_q;
  assign btn_drop  = drop_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_input_frontend.sv
// Bench for input_frontend (D=4, two sync stages): directed plan plus random button
// activity, checked every cycle against a sliding-window reference of the raw input.
module tb_input_frontend;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        btn_raw = 1'b0;
  logic        busy = 1'b0;
  logic [15:0] sw = 16'd0;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        btn_edge;
  logic        btn_level;
  logic        btn_drop;

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;
  int n_drop = 0;

  // Reference: raw button history per edge, switch history, modelled outputs.
  bit          raw_h[$];
  logic [15:0] sw_h[$];
  logic        m_level;
  logic        m_edge;
  logic        m_drop;
  logic [15:0] m_word;

  input_frontend #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .btn_raw(btn_raw), .sw(sw), .busy(busy),
    .opcode(opcode), .instr(instr), .btn_edge(btn_edge),
    .btn_level(btn_level), .btn_drop(btn_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw_h = {};
    sw_h  = {};
    repeat (D + 3) raw_h.push_back(1'b0);
    repeat (3) sw_h.push_back(16'd0);
    m_level = 1'b0;
    m_edge  = 1'b0;
    m_drop  = 1'b0;
    m_word  = 16'd0;
  endtask

  // The core sees the button two edges late; the level flips once its last D+1
  // visible samples agree on the opposite value.
  task automatic model_edge();
    bit all1, all0;
    raw_h.push_back(btn_raw);
    void'(raw_h.pop_front());
    sw_h.push_back(sw);
    void'(sw_h.pop_front());
    all1 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i <= D; i++) begin
      if (raw_h[i]) all0 = 1'b0;
      else all1 = 1'b0;
    end
    m_edge = 1'b0;
    m_drop = 1'b0;
    if (!m_level && all1) begin
      m_level = 1'b1;
      if (busy) m_drop = 1'b1;
      else begin
        m_edge = 1'b1;
        m_word = sw_h[0];
      end
    end else if (m_level && all0) begin
      m_level = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) model_edge();
    #1;
    check("btn_level", 16'(btn_level), 16'(m_level));
    check("btn_edge", 16'(btn_edge), 16'(m_edge));
    check("btn_drop", 16'(btn_drop), 16'(m_drop));
    check("word", {opcode, instr}, m_word);
    if (btn_edge) n_edge++;
    if (btn_drop) n_drop++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_word", {opcode, instr}, 16'h0000);
    check("rst_pulses", {13'd0, btn_edge, btn_drop, btn_level}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic press_release(input int hold, input int rel);
    btn_raw = 1'b1;
    repeat (hold) step();
    btn_raw = 1'b0;
    repeat (rel) step();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: clean press, pulse on edge k+6 (seventh edge after raw goes high)
    sw = 16'hA5C3;
    n_edge = 0;
    btn_raw = 1'b1;
    repeat (6) step();
    check("t1_no_early_edge", 16'(btn_edge), 16'd0);
    step();
    check("t1_edge_k6", 16'(btn_edge), 16'd1);
    check("t1_opcode", 16'(opcode), 16'h000A);
    check("t1_instr", 16'(instr), 16'h05C3);
    step();
    check("t1_edge_one_cycle", 16'(btn_edge), 16'd0);
    repeat (12) step();
    btn_raw = 1'b0;
    repeat (6) step();
    check("t1_level_before_fall", 16'(btn_level), 16'd1);
    step();
    check("t1_level_fall", 16'(btn_level), 16'd0);
    repeat (4) step();
    check("t1_edge_count", 16'(n_edge), 16'd1);

    // 2: press bounce never qualifies
    do_reset();
    n_edge = 0;
    btn_raw = 1'b1; repeat (3) step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1; repeat (2) step();
    btn_raw = 1'b0; repeat (10) step();
    check("t2_edge_count", 16'(n_edge), 16'd0);
    check("t2_word", {opcode, instr}, 16'h0000);
    check("t2_level", 16'(btn_level), 16'd0);

    // 3: busy reject, then accepted press
    n_edge = 0;
    n_drop = 0;
    busy = 1'b1;
    sw = 16'h1234;
    press_release(20, 10);
    check("t3_drop_count", 16'(n_drop), 16'd1);
    check("t3_busy_no_edge", 16'(n_edge), 16'd0);
    check("t3_word_kept", {opcode, instr}, 16'h0000);
    busy = 1'b0;
    btn_raw = 1'b1;
    repeat (10) step();
    check("t3_edge_count", 16'(n_edge), 16'd1);
    check("t3_word", {opcode, instr}, 16'h1234);

    // 4: switches change while held; latch only moves on a new press
    sw = 16'hFFFF;
    repeat (10) step();
    check("t4_held_word", {opcode, instr}, 16'h1234);
    btn_raw = 1'b0;
    repeat (10) step();
    check("t4_released_word", {opcode, instr}, 16'h1234);
    press_release(12, 10);
    check("t4_new_word", {opcode, instr}, 16'hFFFF);

    // 5: release bounce keeps the level and gives no second edge
    n_edge = 0;
    sw = 16'h5A5A;
    btn_raw = 1'b1;
    repeat (10) step();
    btn_raw = 1'b0; repeat (2) step();
    btn_raw = 1'b1; repeat (10) step();
    check("t5_level_held", 16'(btn_level), 16'd1);
    check("t5_edge_count", 16'(n_edge), 16'd1);
    btn_raw = 1'b0;
    repeat (10) step();

    // 6: reset in PRESS_WAIT, button still held afterwards
    check("t6_prior_word", {opcode, instr}, 16'h5A5A);
    sw = 16'h9ABC;
    btn_raw = 1'b1;
    repeat (4) step();
    do_reset();
    n_edge = 0;
    repeat (6) step();
    check("t6_no_early_edge", 16'(btn_edge), 16'd0);
    step();
    check("t6_edge_k6", 16'(btn_edge), 16'd1);
    check("t6_word", {opcode, instr}, 16'h9ABC);
    btn_raw = 1'b0;
    repeat (10) step();
    check("t6_edge_count", 16'(n_edge), 16'd1);

    // Random button activity, busy and switch changes, one mid-run reset
    for (int seg = 0; seg < 150; seg++) begin
      btn_raw = 1'($urandom_range(0, 1));
      busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) sw = 16'($urandom);
      if (seg == 75) do_reset();
      repeat ($urandom_range(1, 12)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
